// File: rtl/frv_dmem_sram_responder.sv
// Data-memory responder: accepts dmem requests, services them from a byte-laned SRAM
// and returns in-order responses after a fixed minimum latency, with bounded outstanding depth.
module frv_dmem_sram_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0002_0000,
    parameter int          DEPTH       = 1024,
    parameter int          RSP_LAT     = 1,
    parameter int          OUTSTANDING = 2
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        dmem_req,
    input  logic        dmem_wen,
    input  logic [3:0]  dmem_strb,
    input  logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_addr,
    output logic        dmem_gnt,
    input  logic        dmem_recv,
    output logic        dmem_ack,
    output logic        dmem_error,
    output logic [31:0] dmem_rdata,
    output logic [2:0]  outstanding
);

    localparam int          AW   = $clog2(DEPTH);
    localparam int          PW   = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);
    localparam logic [2:0]  LAT  = 3'(RSP_LAT);
    localparam logic [2:0]  MAXO = 3'(OUTSTANDING);
    localparam logic [PW-1:0] LAST = PW'(OUTSTANDING - 1);

    logic [2:0]    r_cnt;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [2:0]    r_age [OUTSTANDING];
    logic [OUTSTANDING-1:0] r_err;

    logic [31:0]   w_off;
    logic          w_in_range;
    logic [AW-1:0] w_idx;
    logic          w_acc;
    logic          w_ack;
    logic          w_retire;
    logic [31:0]   w_head_data;

    // Unsigned subtract makes addresses below the base wrap to huge offsets.
    assign w_off      = dmem_addr - BASE_ADDR;
    assign w_in_range = (w_off < SPAN);
    assign w_idx      = w_off[AW+1:2];

    assign dmem_gnt = g_resetn && dmem_req && (r_cnt < MAXO);
    assign w_acc    = dmem_req && dmem_gnt;

    // Ages only grow with acceptance order, so an eligible head implies in-order return.
    assign w_ack    = (r_cnt != 3'd0) && (r_age[r_rptr] == LAT);
    assign w_retire = w_ack && dmem_recv;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_cnt  <= 3'd0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_acc) begin
                r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_retire) begin
                r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + 1'b1;
            end
            case ({w_acc, w_retire})
                2'b10:   r_cnt <= r_cnt + 3'd1;
                2'b01:   r_cnt <= r_cnt - 3'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Slot metadata needs no reset: a slot is only observed once written at acceptance.
    always_ff @(posedge g_clk) begin
        for (int i = 0; i < OUTSTANDING; i++) begin
            if (r_age[i] != LAT) begin
                r_age[i] <= r_age[i] + 3'd1;
            end
        end
        if (w_acc) begin
            r_age[r_wptr] <= 3'd1;
            r_err[r_wptr] <= !w_in_range;
        end
    end

    // One SRAM per byte lane; the load read lands straight in the response slot.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] r_mem [DEPTH];
        logic [7:0] r_rd  [OUTSTANDING];

        always_ff @(posedge g_clk) begin
            if (w_acc && w_in_range && dmem_wen && dmem_strb[gi]) begin
                r_mem[w_idx] <= dmem_wdata[8*gi +: 8];
            end
        end

        always_ff @(posedge g_clk) begin
            if (w_acc) begin
                r_rd[r_wptr] <= (w_in_range && !dmem_wen) ? r_mem[w_idx] : 8'h00;
            end
        end

        assign w_head_data[8*gi +: 8] = r_rd[r_rptr];
    end

    assign dmem_ack    = w_ack;
    assign dmem_error  = w_ack && r_err[r_rptr];
    assign dmem_rdata  = w_ack ? w_head_data : 32'h0;
    assign outstanding = r_cnt;

endmodule

// File: tb/tb_frv_dmem_sram_responder.sv
// Scoreboard bench for frv_dmem_sram_responder: two configurations (latency 1 / depth 2,
// latency 3 / depth 3), directed scenarios followed by randomized traffic.
module tb_frv_dmem_sram_responder;

    localparam logic [31:0] BASE    = 32'h0002_0000;
    localparam int          DEPTH   = 1024;
    localparam logic [31:0] SPAN_TB = 32'(4 * DEPTH);

    logic g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    int cyc = 0;
    always @(posedge g_clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          acc;
    } rsp_t;

    task automatic chk(input int cfg, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL cfg%0d %s: got 0x%08h, expected 0x%08h (cycle %0d)", cfg, name, act, exp, cyc);
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
        localparam int LAT = (gi == 0) ? 1 : 3;
        localparam int OUT = (gi == 0) ? 2 : 3;

        logic        g_resetn = 1'b0;
        logic        dmem_req = 1'b0;
        logic        dmem_wen = 1'b0;
        logic [3:0]  dmem_strb = 4'h0;
        logic [31:0] dmem_wdata = 32'h0;
        logic [31:0] dmem_addr = 32'h0;
        logic        dmem_recv = 1'b1;
        logic        dmem_gnt;
        logic        dmem_ack;
        logic        dmem_error;
        logic [31:0] dmem_rdata;
        logic [2:0]  outstanding;
        logic        done_m = 1'b0;

        frv_dmem_sram_responder #(
            .BASE_ADDR(BASE), .DEPTH(DEPTH), .RSP_LAT(LAT), .OUTSTANDING(OUT)
        ) u_dut (
            .g_clk(g_clk), .g_resetn(g_resetn),
            .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
            .dmem_wdata(dmem_wdata), .dmem_addr(dmem_addr), .dmem_gnt(dmem_gnt),
            .dmem_recv(dmem_recv), .dmem_ack(dmem_ack), .dmem_error(dmem_error),
            .dmem_rdata(dmem_rdata), .outstanding(outstanding)
        );

        rsp_t        q[$];
        logic [31:0] mem_m [int];
        int          recv_mode = 1;

        // 0 random, 1 always ready, 2 never ready, 3 ready for one cycle then never
        initial forever begin
            @(posedge g_clk);
            #1;
            case (recv_mode)
                0:       dmem_recv = ($urandom_range(0, 3) != 0);
                1:       dmem_recv = 1'b1;
                3:       begin dmem_recv = 1'b1; recv_mode = 2; end
                default: dmem_recv = 1'b0;
            endcase
        end

        task automatic accept(input logic wen, input logic [3:0] strb, input logic [31:0] wd,
                              input logic [31:0] addr);
            logic [31:0] off;
            logic [31:0] w;
            int          idx;
            rsp_t        r;
            off     = addr - BASE;
            r.acc   = cyc;
            r.err   = (off >= SPAN_TB);
            r.rdata = 32'h0;
            if (!r.err) begin
                idx = int'(off >> 2);
                w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
                if (wen) begin
                    for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = wd[8*b +: 8];
                    mem_m[idx] = w;
                end else begin
                    r.rdata = w;
                end
            end
            q.push_back(r);
        endtask

        // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
        task automatic send(input logic wen, input logic [3:0] strb, input logic [31:0] wd,
                            input logic [31:0] addr);
            int waited;
            waited     = 0;
            dmem_req   = 1'b1;
            dmem_wen   = wen;
            dmem_strb  = strb;
            dmem_wdata = wd;
            dmem_addr  = addr;
            forever begin
                #2;
                chk(gi, "outstanding", 32'(outstanding), 32'(q.size()));
                chk(gi, "gnt", 32'(dmem_gnt), 32'(q.size() < OUT));
                if (q.size() < OUT) begin
                    accept(wen, strb, wd, addr);
                    @(posedge g_clk);
                    #1;
                    break;
                end
                @(posedge g_clk);
                #1;
                waited++;
                if (waited > 64) begin
                    chk(gi, "gnt_timeout", 32'(waited), 32'd64);
                    break;
                end
            end
        endtask

        task automatic idle(input int n);
            dmem_req = 1'b0;
            repeat (n) begin
                #2;
                chk(gi, "outstanding", 32'(outstanding), 32'(q.size()));
                chk(gi, "gnt_idle", 32'(dmem_gnt), 32'd0);
                @(posedge g_clk);
                #1;
            end
        endtask

        // One reset cycle with a store presented that must be neither granted nor written.
        task automatic do_reset();
            g_resetn   = 1'b0;
            q.delete();
            dmem_req   = 1'b1;
            dmem_wen   = 1'b1;
            dmem_strb  = 4'hF;
            dmem_wdata = 32'hBAD0_BAD0;
            dmem_addr  = BASE + 32'h20;
            #2;
            chk(gi, "gnt_in_reset", 32'(dmem_gnt), 32'd0);
            @(posedge g_clk);
            #1;
            g_resetn = 1'b1;
            dmem_req = 1'b0;
            chk(gi, "outstanding_after_reset", 32'(outstanding), 32'd0);
            chk(gi, "ack_after_reset", 32'(dmem_ack), 32'd0);
        endtask

        initial begin : mon
            bit exp_ack;
            forever begin
                @(negedge g_clk);
                if (g_resetn) begin
                    exp_ack = (q.size() != 0) && (cyc >= q[0].acc + LAT);
                    chk(gi, "ack", 32'(dmem_ack), 32'(exp_ack));
                    if (dmem_ack && q.size() != 0) begin
                        chk(gi, "error", 32'(dmem_error), 32'(q[0].err));
                        chk(gi, "rdata", dmem_rdata, q[0].rdata);
                        if (dmem_recv) begin
                            $display("cfg%0d rsp err=%0d rdata=%08h acc=%0d ret=%0d",
                                     gi, dmem_error, dmem_rdata, q[0].acc, cyc);
                            void'(q.pop_front());
                        end
                    end else if (!dmem_ack) begin
                        chk(gi, "idle_error", 32'(dmem_error), 32'd0);
                        chk(gi, "idle_rdata", dmem_rdata, 32'd0);
                    end
                end
            end
        end

        initial begin : drv
            logic [31:0] oor [4];
            logic [31:0] a;
            int          k;
            oor[0] = 32'h0000_0100;
            oor[1] = BASE + SPAN_TB;
            oor[2] = BASE - 32'd4;
            oor[3] = 32'hFFFF_FFFC;

            repeat (2) @(posedge g_clk);
            #1;
            do_reset();

            for (int w = 0; w < 16; w++) send(1'b1, 4'hF, $urandom, BASE + 32'(4 * w));
            send(1'b1, 4'hF, $urandom, BASE + SPAN_TB - 32'd4);
            send(1'b1, 4'hF, 32'hDEAD_BEEF, BASE + 32'h10);
            send(1'b1, 4'hF, 32'hAABB_CCDD, BASE + 32'h14);
            idle(LAT + 3);

            send(1'b0, 4'h0, 32'h0, BASE + 32'h10);
            idle(LAT + 2);

            send(1'b1, 4'b0101, 32'h1122_3344, BASE + 32'h14);
            send(1'b0, 4'h0, 32'h0, BASE + 32'h14);
            idle(LAT + 3);

            recv_mode = 2;
            idle(1);
            fork
                begin
                    repeat (OUT + 4) @(posedge g_clk);
                    recv_mode = 3;
                end
            join_none
            for (int i = 0; i <= OUT; i++) send(1'b0, 4'h0, 32'h0, BASE + 32'(4 * i));
            recv_mode = 1;
            idle(LAT + 6);

            send(1'b0, 4'h0, 32'h0, oor[0]);
            send(1'b1, 4'hF, 32'hFFFF_FFFF, oor[1]);
            send(1'b0, 4'h0, 32'h0, BASE + SPAN_TB - 32'd4);
            send(1'b0, 4'h0, 32'h0, BASE);
            send(1'b1, 4'hF, 32'h5555_AAAA, oor[2]);
            send(1'b1, 4'hF, 32'h5555_AAAA, oor[3]);
            send(1'b0, 4'h0, 32'h0, BASE + SPAN_TB - 32'd4);
            idle(LAT + 4);

            recv_mode = 2;
            idle(1);
            send(1'b1, 4'hF, 32'h7777_0007, BASE + 32'h1C);
            send(1'b0, 4'h0, 32'h0, BASE + 32'h1C);
            do_reset();
            recv_mode = 1;
            idle(2);
            send(1'b0, 4'h0, 32'h0, BASE + 32'h1C);
            send(1'b0, 4'h0, 32'h0, BASE + 32'h20);
            idle(LAT + 4);

            recv_mode = 0;
            repeat (250) begin
                if ($urandom_range(0, 9) == 0) a = oor[$urandom_range(0, 3)];
                else a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
                send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, a);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end

            recv_mode = 1;
            k = 0;
            while (q.size() != 0 && k < 100) begin
                idle(1);
                k++;
            end
            chk(gi, "drain", 32'(q.size()), 32'd0);
            done_m = 1'b1;
        end
    end

    initial begin
        fork
            wait (g_cfg[0].done_m && g_cfg[1].done_m);
            #1_000_000;
        join_any
        if (!(g_cfg[0].done_m && g_cfg[1].done_m)) begin
            n_total++;
            $display("FAIL watchdog: got done=%0d%0d, expected done=11", g_cfg[1].done_m, g_cfg[0].done_m);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/frv_dmem_sram_responder.md
Name: frv_dmem_sram_responder

Overview:
Responder end of the core data-memory interface. It accepts requests on the dmem_req/dmem_gnt channel and returns responses on the dmem_recv/dmem_ack channel, backed by an internal byte-strobed word SRAM. It sits on the far side of the memory pipeline stage in the integration and formal/simulation harnesses, and has configurable response latency and outstanding-request depth. Out-of-range addresses produce error responses.

Parameters:
BASE_ADDR, 32'h0002_0000, byte address of word 0 of the SRAM.
DEPTH, 1024, number of 32-bit words; power of two.
RSP_LAT, 1, minimum number of cycles from acceptance to the first cycle dmem_ack can assert; 1..4.
OUTSTANDING, 2, maximum number of accepted but not yet retired requests; 1..4.

Ports:
g_clk  input  1  global clock
g_resetn  input  1  reset; synchronous, active-low
dmem_req  input  1  request valid
dmem_wen  input  1  1 = store, 0 = load
dmem_strb  input  4  byte write strobes (stores only)
dmem_wdata  input  32  store data, byte lanes already aligned
dmem_addr  input  32  byte address; bits [1:0] ignored
dmem_gnt  output  1  request accepted this cycle
dmem_recv  input  1  requester can accept a response this cycle
dmem_ack  output  1  response valid
dmem_error  output  1  response is a bus error
dmem_rdata  output  32  load data
outstanding  output  3  debug: count of accepted, unretired requests

Behaviour:
- Reset (g_resetn low at a clock edge): dmem_ack=0, dmem_error=0, dmem_rdata=0, outstanding=0, and every in-flight entry is discarded. dmem_gnt=0 while g_resetn is low. SRAM contents are not reset. A request presented during reset is neither accepted nor written.
- Grant: dmem_gnt = dmem_req && (outstanding < OUTSTANDING).
  - dmem_gnt depends only on registered state and dmem_req. It never depends on a same-cycle retire.
  - Acceptance = dmem_req && dmem_gnt.
- Address check: in_range = (dmem_addr - BASE_ADDR) < 4*DEPTH, evaluated as an unsigned 32-bit comparison. The word index is (dmem_addr - BASE_ADDR)[log2(DEPTH)+1:2].
- On acceptance of an in-range store: each byte lane i with dmem_strb[i]=1 is written at the accepting edge. The response carries error=0 and rdata=0.
- On acceptance of an in-range load: the word is read at the accepting edge, reflecting all previously accepted stores. The response carries error=0 and rdata=word.
- On acceptance of an out-of-range request: no SRAM access. The response carries error=1 and rdata=0.
- Response path: each accepted entry becomes eligible RSP_LAT cycles after its acceptance cycle. Eligible entries go into a FIFO of depth OUTSTANDING.
  - The head of the FIFO drives dmem_ack, dmem_error and dmem_rdata directly from registers.
  - When the FIFO is empty: dmem_ack=0, dmem_error=0, dmem_rdata=0.
- Retire = dmem_ack && dmem_recv. On retire the head is popped at the edge. The next entry, if eligible, is presented in the following cycle.
- While dmem_ack=1 and dmem_recv=0, the head and its outputs hold stable.
- Ordering: responses are returned strictly in acceptance order.
- outstanding update: +1 on acceptance, -1 on retire, unchanged when both occur in the same cycle. Range 0..OUTSTANDING; it never overflows or underflows.
- Full: while outstanding == OUTSTANDING, dmem_gnt=0. A retire in cycle T allows a grant in cycle T+1.
- Back-to-back: with outstanding < OUTSTANDING, a new request may be accepted in the same cycle another entry retires.
- Internal latency stages never stall. Total entries are bounded by OUTSTANDING, which equals the FIFO depth.
- Address bits [1:0] are ignored, and the strobes are trusted as given by the requester.

Test Plan:
- Load latency: BASE=0x20000, RSP_LAT=1. Preload word 0x20010 = 0xDEADBEEF. Load 0x20010 accepted at cycle T with dmem_recv=1 -> dmem_ack=1, dmem_error=0, dmem_rdata=0xDEADBEEF at T+1; dmem_ack=0 at T+2.
- Strobed store then load: store 0x11223344 with strb=4'b0101 to a word holding 0xAABBCCDD, followed back-to-back by a load of the same word -> both acked in order; load rdata=0xAA22CC44.
- Backpressure and full: OUTSTANDING=2, dmem_recv=0, three back-to-back requests -> first two granted, third sees dmem_gnt=0 and outstanding=2. Raise dmem_recv for one cycle -> one retire, third granted the next cycle.
- Error response: load of 0x00000100 and store to BASE+4*DEPTH -> both acked with dmem_error=1, dmem_rdata=0; SRAM unchanged.
- RSP_LAT=3: load accepted at T with dmem_recv held high -> dmem_ack first asserts at T+3, not earlier.
- Reset mid-operation: two requests outstanding, g_resetn=0 for one cycle -> dmem_ack=0, outstanding=0 after the edge; no stale response appears afterwards; a store accepted before the reset persists.
